aes_key_expand: RTL and testbench

//   Iterative AES-128 key schedule sitting directly upstream of the encryption core.
//   - Accepts one 128-bit cipher key over a valid/ready handshake.
//   - Produces round keys rk[0..10] at one round key per clock.
//   - Stores all round keys and serves them through a random-access read port

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_key_expand_if.sv | 30 +++
 rtl/aes_sbox.sv | 26 ++
 rtl/aes_key_expand.sv | 125 ++++++++++++
 tb/tb_aes_key_expand.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: key-expansion FSM encoding, round constants and GF(2^8) arithmetic
// reused by the key schedule and the decryption core.
package aes_pkg;

   localparam int NUM_ROUNDS_128 = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } kexp_state_t;

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] r;
      case (rnd)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // One column of InvMixColumns, byte 0 in [31:24].
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] b0, b1, b2, b3;
      logic [7:0] r0, r1, r2, r3;
      b0 = c[31:24];
      b1 = c[23:16];
      b2 = c[15:8];
      b3 = c[7:0];
      r0 = gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09);
      r1 = gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d);
      r2 = gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b);
      r3 = gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e);
      return {r0, r1, r2, r3};
   endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-load handshake and round-key read port of the AES-128 key schedule.
// AES_KEYEXP_INVKEY_EN adds the equivalent-inverse-cipher round-key output.
interface aes_key_expand_if;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] keyin;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;
   logic         keys_valid;
   logic         busy;
`ifdef AES_KEYEXP_INVKEY_EN
   logic [127:0] rk_dec_out;
`endif

   modport master (
      output key_valid, keyin, rk_idx,
      input  key_ready, rk_out, keys_valid, busy
`ifdef AES_KEYEXP_INVKEY_EN
      , input rk_dec_out
`endif
   );

   modport slave (
      input  key_valid, keyin, rk_idx,
      output key_ready, rk_out, keys_valid, busy
`ifdef AES_KEYEXP_INVKEY_EN
      , output rk_dec_out
`endif
   );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (a^254) followed by the affine map.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] data,
   output logic [7:0] sub
);

   logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;

   always_comb begin
      a2   = gf_mul(data, data);
      a3   = gf_mul(a2, data);
      a6   = gf_mul(a3, a3);
      a12  = gf_mul(a6, a6);
      a15  = gf_mul(a12, a3);
      a30  = gf_mul(a15, a15);
      a60  = gf_mul(a30, a30);
      a120 = gf_mul(a60, a60);
      a240 = gf_mul(a120, a120);
      inv  = gf_mul(gf_mul(a240, a12), a2);
      sub  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store with a
// random-access read port. AES_KEYEXP_INVKEY_EN adds InvMixColumns'd decryption keys.
//
//   state  | meaning
//   IDLE   | no schedule stored, ready for a key
//   EXPAND | writing rk[rnd] each clock, key_ready low
//   READY  | full schedule stored, a new key restarts expansion
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_128,
   parameter bit RD_REG     = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   aes_key_expand_if.slave  bus
);

   localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

   kexp_state_t  state_q, state_d;
   logic [3:0]   rnd_q;
   logic [127:0] rk_q [0:NUM_ROUNDS];
   logic         accept;
   logic [3:0]   prev_idx;
   logic [127:0] prev_rk;
   logic [31:0]  rot_w, sub_w, t_w;
   logic [31:0]  n0, n1, n2, n3;
   logic [3:0]   rd_idx;
   logic [127:0] rd_word;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      bus.key_ready  = 1'b0;
      bus.busy       = 1'b0;
      bus.keys_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.key_ready = 1'b1;
            if (bus.key_valid) state_d = EXPAND;
         end
         EXPAND: begin
            bus.busy = 1'b1;
            if (rnd_q == LAST_RND) state_d = READY;
         end
         READY: begin
            bus.key_ready  = 1'b1;
            bus.keys_valid = 1'b1;
            if (bus.key_valid) state_d = EXPAND;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = bus.key_valid && bus.key_ready;

   // Round function operates on the previously written key, rk[rnd-1].
   assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
   assign prev_rk  = rk_q[prev_idx];
   assign rot_w    = {prev_rk[23:0], prev_rk[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .data (rot_w[8*i +: 8]),
         .sub  (sub_w[8*i +: 8])
      );
   end

   assign t_w = sub_w ^ {rcon(rnd_q), 24'h000000};
   assign n0  = prev_rk[127:96] ^ t_w;
   assign n1  = prev_rk[95:64]  ^ n0;
   assign n2  = prev_rk[63:32]  ^ n1;
   assign n3  = prev_rk[31:0]   ^ n2;

   always_ff @(posedge clk) begin
      if (rst) begin
         rnd_q <= 4'd0;
         for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
      end else if (accept) begin
         rk_q[0] <= bus.keyin;
         rnd_q   <= 4'd1;
      end else if (state_q == EXPAND) begin
         rk_q[rnd_q] <= {n0, n1, n2, n3};
         rnd_q       <= (rnd_q == LAST_RND) ? 4'd0 : rnd_q + 4'd1;
      end
   end

   assign rd_idx  = (bus.rk_idx <= LAST_RND) ? bus.rk_idx : 4'd0;
   assign rd_word = (bus.rk_idx <= LAST_RND) ? rk_q[rd_idx] : '0;

`ifdef AES_KEYEXP_INVKEY_EN
   logic [127:0] dec_word;
   // First and last round keys are used unmixed by the equivalent inverse cipher.
   assign dec_word = (bus.rk_idx == 4'd0 || bus.rk_idx >= LAST_RND) ? rd_word :
                     {inv_mix_col(rd_word[127:96]), inv_mix_col(rd_word[95:64]),
                      inv_mix_col(rd_word[63:32]),  inv_mix_col(rd_word[31:0])};
`endif

   if (RD_REG) begin : g_rd_reg
      always_ff @(posedge clk) begin
         if (rst) begin
            bus.rk_out <= '0;
`ifdef AES_KEYEXP_INVKEY_EN
            bus.rk_dec_out <= '0;
`endif
         end else begin
            bus.rk_out <= rd_word;
`ifdef AES_KEYEXP_INVKEY_EN
            bus.rk_dec_out <= dec_word;
`endif
         end
      end
   end else begin : g_rd_comb
      assign bus.rk_out = rd_word;
`ifdef AES_KEYEXP_INVKEY_EN
      assign bus.rk_dec_out = dec_word;
`endif
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: registered-read and combinational-read instances
// driven in lockstep; expected values are queued with a due cycle and checked by a monitor.
module tb_aes_key_expand;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_key_expand_if if_r ();
   aes_key_expand_if if_c ();

   aes_key_expand #(.RD_REG(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(if_r.slave));
   aes_key_expand #(.RD_REG(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   localparam int K_RK_R  = 0;
   localparam int K_RK_C  = 1;
   localparam int K_KV    = 2;
   localparam int K_BUSY  = 3;
   localparam int K_KR    = 4;
   localparam int K_DEC_R = 5;
   localparam int K_DEC_C = 6;

   typedef struct {
      int           kind;
      int           due;
      logic [127:0] exp;
      string        name;
   } item_t;

   item_t sbq[$];
   int    checks = 0;
   int    errors = 0;

   localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY2 = 128'h5468617473206d79204b756e67204675;

   logic [127:0] rk_a [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   localparam logic [127:0] K2_RK1  = 128'he232fcf191129188b159e4e6d679a293;
   localparam logic [127:0] K2_RK10 = 128'h28fddef86da4244accc0a4fe3b316f26;

   function automatic logic [7:0] m_xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] b, input int f);
      logic [7:0] m2, m4, m8;
      m2 = m_xt(b);
      m4 = m_xt(m2);
      m8 = m_xt(m4);
      case (f)
         9:       return m8 ^ b;
         11:      return m8 ^ m2 ^ b;
         13:      return m8 ^ m4 ^ b;
         14:      return m8 ^ m4 ^ m2;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] m_imc(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
      return {m_mul(a0,14) ^ m_mul(a1,11) ^ m_mul(a2,13) ^ m_mul(a3,9),
              m_mul(a0,9)  ^ m_mul(a1,14) ^ m_mul(a2,11) ^ m_mul(a3,13),
              m_mul(a0,13) ^ m_mul(a1,9)  ^ m_mul(a2,14) ^ m_mul(a3,11),
              m_mul(a0,11) ^ m_mul(a1,13) ^ m_mul(a2,9)  ^ m_mul(a3,14)};
   endfunction

   function automatic logic [127:0] dec_of(input int idx, input logic [127:0] rk);
      if (idx >= 1 && idx <= 9)
         return {m_imc(rk[127:96]), m_imc(rk[95:64]), m_imc(rk[63:32]), m_imc(rk[31:0])};
      return rk;
   endfunction

   function automatic logic [127:0] observe(input int kind);
      case (kind)
         K_RK_R:  return if_r.rk_out;
         K_RK_C:  return if_c.rk_out;
         K_KV:    return {127'd0, if_r.keys_valid};
         K_BUSY:  return {127'd0, if_r.busy};
         K_KR:    return {127'd0, if_r.key_ready};
`ifdef AES_KEYEXP_INVKEY_EN
         K_DEC_R: return if_r.rk_dec_out;
         K_DEC_C: return if_c.rk_dec_out;
`endif
         default: return 'x;
      endcase
   endfunction

   task automatic push(input int kind, input int due, input logic [127:0] exp, input string name);
      item_t it;
      it.kind = kind;
      it.due  = due;
      it.exp  = exp;
      it.name = name;
      sbq.push_back(it);
   endtask

   always @(negedge clk) begin
      logic [127:0] got;
      for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
         if (sbq[i].due == cyc) begin
            got = observe(sbq[i].kind);
            checks++;
            if (got !== sbq[i].exp) begin
               errors++;
               $display("FAIL %s @cyc %0d: got %h expected %h", sbq[i].name, cyc, got, sbq[i].exp);
            end
            sbq.delete(i);
         end
      end
   end

   task automatic set_key(input logic v, input logic [127:0] k);
      if_r.key_valid = v; if_c.key_valid = v;
      if_r.keyin     = k; if_c.keyin     = k;
   endtask

   task automatic set_idx(input int idx);
      if_r.rk_idx = 4'(idx);
      if_c.rk_idx = 4'(idx);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulse key_valid for one edge; the accept edge number is cyc on return.
   task automatic send_key(input logic [127:0] k, input bit chk);
      set_key(1'b1, k);
      step(1);
      set_key(1'b0, k);
      if (chk) begin
         push(K_KV,   cyc,      128'd0, "kv_after_accept");
         push(K_BUSY, cyc,      128'd1, "busy_expand");
         push(K_KR,   cyc,      128'd0, "ready_expand");
         push(K_KV,   cyc + 9,  128'd0, "kv_at_9");
         push(K_KV,   cyc + 10, 128'd1, "kv_at_10");
         push(K_BUSY, cyc + 10, 128'd0, "busy_done");
      end
   endtask

   task automatic rd(input int idx, input logic [127:0] exp, input string name);
      set_idx(idx);
      push(K_RK_C, cyc,     exp, {name, "_comb"});
      push(K_RK_R, cyc + 1, exp, {name, "_reg"});
`ifdef AES_KEYEXP_INVKEY_EN
      push(K_DEC_C, cyc,     dec_of(idx, exp), {name, "_dec_comb"});
      push(K_DEC_R, cyc + 1, dec_of(idx, exp), {name, "_dec_reg"});
`endif
      step(1);
   endtask

   task automatic reset_checks();
      push(K_KR,   cyc, 128'd1, "rst_key_ready");
      push(K_KV,   cyc, 128'd0, "rst_keys_valid");
      push(K_BUSY, cyc, 128'd0, "rst_busy");
      push(K_RK_R, cyc, 128'd0, "rst_rk_out_reg");
      push(K_RK_C, cyc, 128'd0, "rst_rk_out_comb");
`ifdef AES_KEYEXP_INVKEY_EN
      push(K_DEC_R, cyc, 128'd0, "rst_dec_reg");
`endif
   endtask

   initial begin
      int a;
      set_key(1'b0, '0);
      set_idx(0);
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      reset_checks();

      // Vector 1: full sweep of both read ports plus out-of-range indices.
      send_key(KEY1, 1'b1);
      step(10);
      for (int i = 0; i <= 10; i++) rd(i, rk_a[i], $sformatf("k1_rk%0d", i));
      for (int i = 11; i < 16; i++) rd(i, 128'd0, $sformatf("oor_idx%0d", i));

      // Vector 2
      send_key(KEY2, 1'b1);
      step(10);
      rd(0,  KEY2,    "k2_rk0");
      rd(1,  K2_RK1,  "k2_rk1");
      rd(10, K2_RK10, "k2_rk10");

      // Held key_valid: second key waits for READY, then keys_valid drops on accept.
      set_idx(0);
      set_key(1'b1, KEY1);
      step(1);
      a = cyc;
      set_key(1'b1, KEY2);
      push(K_KV, a, 128'd0, "hs_kv_drop_from_ready");
      for (int i = 0; i < 10; i++) push(K_KR, a + i, 128'd0, $sformatf("hs_ready_low%0d", i));
      push(K_KR,   a + 10, 128'd1, "hs_ready_back");
      push(K_KV,   a + 10, 128'd1, "hs_kv_high");
      push(K_RK_C, a + 10, KEY1,   "hs_key2_not_taken_comb");
      push(K_RK_R, a + 10, KEY1,   "hs_key2_not_taken_reg");
      push(K_KV,   a + 11, 128'd0, "hs_kv_drop_second");
      push(K_BUSY, a + 11, 128'd1, "hs_busy_second");
      push(K_RK_C, a + 11, KEY2,   "hs_key2_taken");
      step(11);
      set_key(1'b0, '0);
      step(10);
      rd(1,  K2_RK1,  "hs_k2_rk1");
      rd(10, K2_RK10, "hs_k2_rk10");

      // Reset at expansion cycle 5, then a clean re-expansion.
      send_key(KEY2, 1'b0);
      step(4);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      reset_checks();
      send_key(KEY1, 1'b1);
      step(10);
      rd(0,  rk_a[0],  "rr_rk0");
      rd(1,  rk_a[1],  "rr_rk1");
      rd(5,  rk_a[5],  "rr_rk5");
      rd(10, rk_a[10], "rr_rk10");

      step(3);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d checks never reached, expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
